// File: rtl/serial_mag_cmp16.sv
// serial_mag_cmp16: nibble-serial magnitude comparator with a 74x85-style cascade input.
// The LSB nibble goes first, so the most significant differing nibble decides the result.
`timescale 1ns/1ps
module serial_mag_cmp16 #(
  parameter int NIB = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4*NIB-1:0] a_in,
  input  logic [4*NIB-1:0] b_in,
  input  logic             ia_lt_b,
  input  logic             ia_eq_b,
  input  logic             ia_gt_b,
  input  logic             en,
  output logic             busy,
  output logic             done,
  output logic             oa_lt_b,
  output logic             oa_eq_b,
  output logic             oa_gt_b
);
  localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [4*NIB-1:0] r_a, r_b;
  logic             r_lt, r_eq, r_gt;
  logic [3:0]       w_na, w_nb;
  logic             w_last, w_neq;
  assign w_na   = 4'(r_a >> (4 * r_cnt));
  assign w_nb   = 4'(r_b >> (4 * r_cnt));
  assign w_neq  = w_na == w_nb;
  assign w_last = r_cnt == CW'(NIB - 1);
  assign busy   = r_state == RUN;
  assign done   = r_state == DONE;
  assign oa_lt_b = r_lt & en;
  assign oa_eq_b = r_eq & en;
  assign oa_gt_b = r_gt & en;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_state <= RUN;
      r_cnt   <= '0;
      r_a     <= a_in;
      r_b     <= b_in;
      r_eq    <= ia_eq_b;
      r_gt    <= ~(ia_lt_b | ia_eq_b);
      r_lt    <= ~(ia_gt_b | ia_eq_b);
    end else if (r_state == RUN) begin
      r_eq    <= w_neq & r_eq;
      r_gt    <= (w_na > w_nb) | (w_neq & r_gt);
      r_lt    <= (w_na < w_nb) | (w_neq & r_lt);
      r_cnt   <= w_last ? r_cnt : r_cnt + 1'b1;
      r_state <= w_last ? DONE : RUN;
    end else if (r_state != IDLE) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_mag_cmp16.sv
// tb_serial_mag_cmp16: directed and random compares against a whole-word arithmetic model.
`timescale 1ns/1ps
module tb_serial_mag_cmp16;
  localparam int NIB = 4;
  logic clk = 0, rst = 1, start = 0, en = 1;
  logic [15:0] a_in = 0, b_in = 0;
  logic ia_lt_b = 0, ia_eq_b = 0, ia_gt_b = 0;
  logic busy, done, oa_lt_b, oa_eq_b, oa_gt_b;
  int errors = 0, checks = 0;

  serial_mag_cmp16 #(.NIB(NIB)) dut (
    .clk(clk), .rst(rst), .start(start), .a_in(a_in), .b_in(b_in),
    .ia_lt_b(ia_lt_b), .ia_eq_b(ia_eq_b), .ia_gt_b(ia_gt_b), .en(en),
    .busy(busy), .done(done), .oa_lt_b(oa_lt_b), .oa_eq_b(oa_eq_b), .oa_gt_b(oa_gt_b)
  );

  always #5 clk = ~clk;

  // Result as {lt,eq,gt}; cascade {lt,eq,gt} only matters when the words are equal.
  function automatic logic [2:0] model(input int unsigned a, input int unsigned b, input logic [2:0] ia);
    if (a > b) return 3'b001;
    if (a < b) return 3'b100;
    return {~(ia[0] | ia[1]), ia[1], ~(ia[2] | ia[1])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic [2:0] ia,
                         input bit scramble, input bit repulse, input bit en_drop, input bit hold);
    logic [2:0] exp;
    exp = model(a, b, ia);
    @(negedge clk);
    a_in = a; b_in = b; {ia_lt_b, ia_eq_b, ia_gt_b} = ia; start = 1;
    @(posedge clk);
    #1 if (!hold) start = 0;
    if (scramble) begin
      a_in = 16'hFFFF; b_in = 16'($urandom); {ia_lt_b, ia_eq_b, ia_gt_b} = 3'($urandom);
    end
    for (int j = 0; j < NIB; j++) begin
      @(negedge clk);
      chk("busy_run", busy, 1);
      chk("done_run", done, 0);
      if (repulse) start = (j == 1);
    end
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("result", {oa_lt_b, oa_eq_b, oa_gt_b}, exp);
    if (en_drop) begin
      en = 0;
      #1 chk("gated_done", {oa_lt_b, oa_eq_b, oa_gt_b}, 0);
      chk("done_gated", done, 1);
    end
    @(negedge clk);
    chk("done_idle", done, 0);
    chk("busy_idle", busy, 0);
    if (en_drop) begin
      chk("gated_idle", {oa_lt_b, oa_eq_b, oa_gt_b}, 0);
      en = 1;
      #1;
    end
    chk("held_result", {oa_lt_b, oa_eq_b, oa_gt_b}, exp);
    if (hold) begin
      @(negedge clk);
      chk("b2b_busy", busy, 1);
      start = 0;
      repeat (NIB - 1) @(negedge clk);
      @(negedge clk);
      chk("b2b_done", done, 1);
      chk("b2b_result", {oa_lt_b, oa_eq_b, oa_gt_b}, exp);
    end
  endtask

  initial begin
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {oa_lt_b, oa_eq_b, oa_gt_b}, 0);
    @(negedge clk) rst = 0;
    run_cmp(16'h1234, 16'h1234, 3'b010, 0, 0, 0, 0);
    run_cmp(16'h8000, 16'h7FFF, 3'b010, 0, 0, 0, 0);
    run_cmp(16'h00FF, 16'h0100, 3'b010, 0, 0, 0, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b001, 0, 0, 0, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b100, 0, 0, 0, 0);
    run_cmp(16'hBEEF, 16'hBEEF, 3'b000, 0, 0, 0, 0);
    run_cmp(16'h0001, 16'h0002, 3'b010, 1, 1, 0, 0);
    run_cmp(16'h0001, 16'h0002, 3'b010, 0, 0, 1, 0);
    run_cmp(16'h4321, 16'h4320, 3'b010, 0, 0, 0, 1);
    // Abort during the RUN cycle that processes nibble 2.
    @(negedge clk);
    a_in = 16'h1234; b_in = 16'h1234; {ia_lt_b, ia_eq_b, ia_gt_b} = 3'b010; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    #1 chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", {oa_lt_b, oa_eq_b, oa_gt_b}, 0);
    @(negedge clk) rst = 0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      chk("abort_nodone", done, 0);
    end
    run_cmp(16'h0005, 16'h0003, 3'b010, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 2) == 0) ? ra : 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = (ra & 16'hFF0F) | (16'($urandom) & 16'h00F0);
      run_cmp(ra, rb, 3'($urandom), 1'($urandom), 0, 0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
